// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
//   state_t          : sequencer FSM encoding (IDLE / RUN / DONE)
//   SERIAL_ADD_WIDTH : default operand/result width
package serial_add_pkg;

  localparam int unsigned SERIAL_ADD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, purely combinational.
//   i_a, i_b : addend bits
//   i_ci     : carry in
//   o_s_c    : sum bit
//   o_co_c   : carry out
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_ci,
  output logic o_s_c,
  output logic o_co_c
);

  assign o_s_c  = i_a ^ i_b ^ i_ci;
  assign o_co_c = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one full_adder cell is reused over
// WIDTH cycles, LSB first. Operands enter on a start valid/ready handshake,
// the result leaves on a result valid/ready handshake.
//   clk, rst_n              : clock, async active-low reset
//   start_valid/start_ready : operand handshake (ready only in IDLE)
//   a, b, sub               : operands and op select (1 = a-b), sampled on accept
//   flush                   : synchronous abort of RUN/DONE
//   busy                    : high while bits are being processed
//   res_valid/res_ready     : result handshake (valid only in DONE)
//   sum, cout               : result and carry out (sub: 1 = no borrow)
//   ovf                     : signed overflow, only with SERIAL_ADD_CTRL_OVF_EN
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = SERIAL_ADD_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             flush,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_CTRL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_start_ready;
  logic               r_busy;
  logic               r_res_valid;
  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-2:0]   r_res_sh;
  logic               r_carry;
  logic [CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               w_accept;
  logic               w_step;
  logic               w_last;
  logic               w_fa_s;
  logic               w_fa_co;
  logic [WIDTH-1:0]   w_res_nxt;

  // Per-cycle adder cell
  full_adder u_fa (
    .i_a    (r_a_sh[0]),
    .i_b    (r_b_sh[0]),
    .i_ci   (r_carry),
    .o_s_c  (w_fa_s),
    .o_co_c (w_fa_co)
  );

  // New sum bit enters at the MSB; the low WIDTH-1 bits are already computed.
  assign w_res_nxt = {w_fa_s, r_res_sh};

  // Next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start_valid && r_start_ready) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (flush) begin
          w_state_nxt = IDLE;
        end else begin
          w_step = 1'b1;
          if (r_count == CNT_W'(WIDTH - 1)) begin
            w_last      = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        if (flush || res_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register with registered handshake/status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_start_ready <= 1'b1;
      r_busy        <= 1'b0;
      r_res_valid   <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_start_ready <= (w_state_nxt == IDLE);
      r_busy        <= (w_state_nxt == RUN);
      r_res_valid   <= (w_state_nxt == DONE);
    end
  end

  // Operand/result shift registers, carry flop and bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_res_sh <= '0;
      r_carry  <= 1'b0;
      r_count  <= '0;
    end else if (w_accept) begin
      // Subtraction as a + ~b + 1: invert b and preset the carry.
      r_a_sh   <= a;
      r_b_sh   <= sub ? ~b : b;
      r_carry  <= sub;
      r_count  <= '0;
    end else if (w_step) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_res_nxt[WIDTH-1:1];
      r_carry  <= w_fa_co;
      r_count  <= r_count + CNT_W'(1);
    end
  end

  // Visible result, loaded only on entry to DONE and held otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
    end else if (w_last) begin
      r_sum  <= w_res_nxt;
      r_cout <= w_fa_co;
    end
  end

`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic r_ovf;

  // In the last RUN cycle r_carry is the carry into bit WIDTH-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_fa_co;
    end
  end

  assign ovf = r_ovf;
`endif

  assign start_ready = r_start_ready;
  assign busy        = r_busy;
  assign res_valid   = r_res_valid;
  assign sum         = r_sum;
  assign cout        = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=8. Expected results are
// queued when an operation is issued; a monitor pops and compares on every
// result handshake. Build with SERIAL_ADD_CTRL_OVF_EN to also check ovf.
module tb_serial_add_ctrl;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start_valid;
  logic         start_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         flush;
  logic         busy;
  logic         res_valid;
  logic         res_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADD_CTRL_OVF_EN
  logic         ovf;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
    .flush       (flush),
    .busy        (busy),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .sum         (sum),
    .cout        (cout)
`ifdef SERIAL_ADD_CTRL_OVF_EN
    ,
    .ovf         (ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares on each result handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_result: got sum %0h with no expected entry", sum);
        end else begin
          e = exp_q.pop_front();
          check("res_sum", 32'(sum), 32'(e.s));
          check("res_cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADD_CTRL_OVF_EN
          check("res_ovf", 32'(ovf), 32'(e.o));
`endif
        end
      end
    end
  end

  // Drive a request and return just after the accepting edge.
  task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts);
    int waited;
    waited = 0;
    @(negedge clk);
    while (!start_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!start_ready) check("start_ready_timeout", 32'(start_ready), 32'd1);
    a = ta; b = tb_v; sub = ts; start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    a = ~ta; b = ~tb_v; sub = ~ts;  // later changes must not matter
  endtask

  // Full operation: latency, busy length, optional backpressure, return to IDLE.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                        input logic [W-1:0] es, input logic ec, input logic eo, input int stall);
    int edges;
    int busy_cnt;
    exp_t e;
    e.s = es; e.c = ec; e.o = eo;
    exp_q.push_back(e);
    res_ready = (stall == 0);
    issue(ta, tb_v, ts);
    edges    = 1;
    busy_cnt = busy ? 1 : 0;
    while (!res_valid && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (busy) busy_cnt++;
    end
    check("latency_edges", 32'(edges), 32'(W + 1));
    check("busy_cycles", 32'(busy_cnt), 32'(W));
    check("ready_low_in_done", 32'(start_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 32'(res_valid), 32'd1);
      check("stall_sum", 32'(sum), 32'(es));
      check("stall_cout", 32'(cout), 32'(ec));
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_valid", 32'(res_valid), 32'd0);
    check("post_hs_ready", 32'(start_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
    flush = 1'b0; res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 0);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 0);
    run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, 5);

    // Flush on the 4th RUN cycle: back to IDLE, no result, sum held.
    issue(8'h55, 8'h22, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_ready", 32'(start_ready), 32'd1);
    check("flush_sum_held", 32'(sum), 32'h96);
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    run_op(8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 1'b0, 0);

    // Asynchronous reset in the middle of RUN.
    issue(8'hAA, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_start_ready", 32'(start_ready), 32'd1);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_res_valid", 32'(res_valid), 32'd0);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_CTRL_OVF_EN
    check("arst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_op(8'h21, 8'h13, 1'b0, 8'h34, 1'b0, 1'b0, 0);

    // Signed-overflow cases (ovf compared only when the feature is built in).
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
    run_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 0);

    repeat (2) @(posedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
